rv32i_ctrl_alu_dmem: RTL and testbench

Single-cycle RV32I execute/memory slice: combinational main control decoder, 32-bit ALU and word-addressed data memory, in one block. Sits between the register file/sign-extender (which supply operands) and the write-back mux/PC (which consume branch, wrt_back_src, alu_results, mem_rdata). Data memory has a preload write port used before execution starts; after init_done, the datapath owns the memory.

---
 rtl/rv32i_ctrl_alu_dmem.sv | 219 +++++++++++++++++++++
 tb/tb_rv32i_ctrl_alu_dmem.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_ctrl_alu_dmem.sv
// rtl/rv32i_ctrl_alu_dmem.sv - single-cycle RV32I control decoder, ALU and data memory slice
//
// Purpose: decodes the current instruction into datapath controls, runs the
// 32-bit ALU on rs1 and (rs2 | immediate), and hosts the word-addressed data
// memory with a preload write port used before execution starts.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset (controls forced to 0, no writes)
//   instruction           current instruction
//   rs1, rs2, immediate   operands; rs2 is also store data
//   init_done             0: preload port owns memory writes; 1: datapath owns them
//   init_w_addr/dat/enb   preload byte address, data, write enable
//   branch                PC select (taken branch or JAL)
//   imm_src, alu_src, alu_ctrl, reg_write, mem_read, mem_write, mem_2_reg, wrt_back_src
//                         decoded controls
//   alu_results, alu_zero ALU result and zero flag
//   mem_rdata             asynchronous load data (0 when not loading)
//   debug_addr/debug_data combinational debug read port, present only when
//                         DMEM_DEBUG_PORT_EN is defined
module rv32i_ctrl_alu_dmem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic                  init_done,
  input  logic [ADDR_WIDTH-1:0] init_w_addr,
  input  logic [DATA_WIDTH-1:0] init_w_dat,
  input  logic                  init_w_enb,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  alu_src,
  output logic [3:0]            alu_ctrl,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_2_reg,
  output logic [1:0]            wrt_back_src,
  output logic [DATA_WIDTH-1:0] alu_results,
  output logic                  alu_zero,
`ifdef DMEM_DEBUG_PORT_EN
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
`endif
  output logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_alt;
  logic       br_sel;
  logic       jal_sel;
  logic       br_taken;

  assign opcode    = instruction[6:0];
  assign func3     = instruction[14:12];
  assign func7_alt = instruction[30];

  // Shared R/I arithmetic map; alt selects SUB (000) or SRA (101).
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b001:  arith_op = ALU_SLL;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b010:  arith_op = ALU_SLT;
      default: arith_op = ALU_SLTU;
    endcase
  endfunction

  always_comb begin
    imm_src      = 3'b000;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_ADD;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    wrt_back_src = 2'b00;
    br_sel       = 1'b0;
    jal_sel      = 1'b0;
    if (!rst) begin
      case (opcode)
        OP_R: begin
          reg_write = 1'b1;
          alu_ctrl  = arith_op(func3, func7_alt);
        end
        OP_I: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          // Only SRAI looks at func7; an immediate with bit 30 set must not turn ADDI into SUB.
          alu_ctrl  = arith_op(func3, func7_alt && (func3 == 3'b101));
        end
        OP_LW: begin
          alu_src      = 1'b1;
          mem_read     = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = 2'b01;
        end
        OP_SW: begin
          alu_src   = 1'b1;
          imm_src   = 3'b001;
          mem_write = 1'b1;
        end
        OP_BR: begin
          imm_src = 3'b010;
          br_sel  = 1'b1;
          case (func3[2:1])
            2'b00:   alu_ctrl = ALU_SUB;
            2'b10:   alu_ctrl = ALU_SLT;
            2'b11:   alu_ctrl = ALU_SLTU;
            default: alu_ctrl = ALU_ADD;
          endcase
        end
        OP_JAL: begin
          jal_sel      = 1'b1;
          imm_src      = 3'b011;
          reg_write    = 1'b1;
          wrt_back_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign mem_2_reg = mem_read;

  // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero; func3 01x is not a branch.
  always_comb begin
    case (func3)
      3'b000, 3'b101, 3'b111: br_taken = alu_zero;
      3'b001, 3'b100, 3'b110: br_taken = !alu_zero;
      default:                br_taken = 1'b0;
    endcase
  end

  assign branch = jal_sel || (br_sel && br_taken);

  logic [DATA_WIDTH-1:0] alu_b;
  logic [4:0]            shamt;

  assign alu_b = alu_src ? immediate : rs2;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (alu_ctrl)
      ALU_ADD:  alu_results = rs1 + alu_b;
      ALU_SUB:  alu_results = rs1 - alu_b;
      ALU_AND:  alu_results = rs1 & alu_b;
      ALU_OR:   alu_results = rs1 | alu_b;
      ALU_XOR:  alu_results = rs1 ^ alu_b;
      ALU_SLL:  alu_results = rs1 << shamt;
      ALU_SRL:  alu_results = rs1 >> shamt;
      ALU_SRA:  alu_results = $unsigned($signed(rs1) >>> shamt);
      ALU_SLT:  alu_results = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1) < $signed(alu_b))};
      ALU_SLTU: alu_results = {{(DATA_WIDTH-1){1'b0}}, (rs1 < alu_b)};
      default:  alu_results = '0;
    endcase
  end

  assign alu_zero = (alu_results == '0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic [IDX_W-1:0]      rd_idx;

  // Preload port owns the write side until init_done; then the store path does.
  assign wr_idx  = init_done ? alu_results[ADDR_WIDTH-1:2] : init_w_addr[ADDR_WIDTH-1:2];
  assign wr_data = init_done ? rs2 : init_w_dat;
  assign wr_en   = init_done ? mem_write : init_w_enb;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_idx    = alu_results[ADDR_WIDTH-1:2];
  assign mem_rdata = mem_read ? mem[rd_idx] : '0;

`ifdef DMEM_DEBUG_PORT_EN
  assign debug_data = mem[debug_addr[ADDR_WIDTH-1:2]];
  logic unused_dbg;
  assign unused_dbg = ^debug_addr[1:0];
`endif

  // Instruction fields and byte-offset bits that this slice never looks at.
  logic unused_bits;
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7], init_w_addr[1:0]};

endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// tb/tb_rv32i_ctrl_alu_dmem.sv - self-checking bench for rv32i_ctrl_alu_dmem
module tb_rv32i_ctrl_alu_dmem;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] immediate;
  logic        init_done;
  logic [9:0]  init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic        branch;
  logic [2:0]  imm_src;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_2_reg;
  logic [1:0]  wrt_back_src;
  logic [31:0] alu_results;
  logic        alu_zero;
  logic [31:0] mem_rdata;
`ifdef DMEM_DEBUG_PORT_EN
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [256];

  rv32i_ctrl_alu_dmem dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .init_done(init_done), .init_w_addr(init_w_addr),
    .init_w_dat(init_w_dat), .init_w_enb(init_w_enb), .branch(branch),
    .imm_src(imm_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .wrt_back_src(wrt_back_src),
    .alu_results(alu_results), .alu_zero(alu_zero),
`ifdef DMEM_DEBUG_PORT_EN
    .debug_addr(debug_addr), .debug_data(debug_data),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        branch;
    logic [2:0]  imm_src;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wbs;
    logic [31:0] res;
    logic        zero;
    logic [31:0] rdata;
  } exp_t;

  // Arithmetic by instruction semantics; returns {alu_ctrl code, result}.
  function automatic logic [35:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: arith = alt ? {4'd1, a - b} : {4'd0, a + b};
      3'd7: arith = {4'd2, a & b};
      3'd6: arith = {4'd3, a | b};
      3'd4: arith = {4'd4, a ^ b};
      3'd1: arith = {4'd5, a << b[4:0]};
      3'd5: arith = alt ? {4'd7, $unsigned($signed(a) >>> b[4:0])} : {4'd6, a >> b[4:0]};
      3'd2: arith = {4'd8, 31'd0, $signed(a) < $signed(b)};
      default: arith = {4'd9, 31'd0, a < b};
    endcase
  endfunction

  function automatic exp_t model(input logic r, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
    exp_t e;
    logic [2:0] f3;
    logic alt;
    logic taken;
    e = '0;
    f3 = ins[14:12];
    alt = ins[30];
    e.res = a + b;
    taken = 1'b0;
    if (!r) begin
      case (ins[6:0])
        7'h33: begin e.reg_write = 1; {e.alu_ctrl, e.res} = arith(f3, alt, a, b); end
        7'h13: begin
          e.reg_write = 1; e.alu_src = 1;
          {e.alu_ctrl, e.res} = arith(f3, alt && f3 == 3'd5, a, imm);
        end
        7'h03: begin
          e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.wbs = 2'b01; e.res = a + imm;
        end
        7'h23: begin e.alu_src = 1; e.imm_src = 3'b001; e.mem_write = 1; e.res = a + imm; end
        7'h63: begin
          e.imm_src = 3'b010;
          case (f3)
            3'd0: begin e.alu_ctrl = 1; e.res = a - b; taken = (a == b); end
            3'd1: begin e.alu_ctrl = 1; e.res = a - b; taken = (a != b); end
            3'd4: begin e.alu_ctrl = 8; e.res = {31'd0, $signed(a) < $signed(b)}; taken = $signed(a) < $signed(b); end
            3'd5: begin e.alu_ctrl = 8; e.res = {31'd0, $signed(a) < $signed(b)}; taken = $signed(a) >= $signed(b); end
            3'd6: begin e.alu_ctrl = 9; e.res = {31'd0, a < b}; taken = a < b; end
            3'd7: begin e.alu_ctrl = 9; e.res = {31'd0, a < b}; taken = a >= b; end
            default: ;
          endcase
          e.branch = taken;
        end
        7'h6f: begin e.branch = 1; e.imm_src = 3'b011; e.reg_write = 1; e.wbs = 2'b10; end
        default: ;
      endcase
    end
    e.zero = (e.res == 32'd0);
    e.rdata = e.mem_read ? ref_mem[e.res[9:2]] : 32'd0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Settle, compare every output against the model, then advance the model memory
  // to reflect the write that the coming clock edge performs.
  task automatic evaluate(input string tag);
    exp_t e;
    #1;
    e = model(rst, instruction, rs1, rs2, immediate);
    check({tag, ".branch"},    {31'd0, branch},       {31'd0, e.branch});
    check({tag, ".imm_src"},   {29'd0, imm_src},      {29'd0, e.imm_src});
    check({tag, ".alu_src"},   {31'd0, alu_src},      {31'd0, e.alu_src});
    check({tag, ".alu_ctrl"},  {28'd0, alu_ctrl},     {28'd0, e.alu_ctrl});
    check({tag, ".reg_write"}, {31'd0, reg_write},    {31'd0, e.reg_write});
    check({tag, ".mem_read"},  {31'd0, mem_read},     {31'd0, e.mem_read});
    check({tag, ".mem_write"}, {31'd0, mem_write},    {31'd0, e.mem_write});
    check({tag, ".mem_2_reg"}, {31'd0, mem_2_reg},    {31'd0, e.mem_read});
    check({tag, ".wbs"},       {30'd0, wrt_back_src}, {30'd0, e.wbs});
    check({tag, ".result"},    alu_results,           e.res);
    check({tag, ".zero"},      {31'd0, alu_zero},     {31'd0, e.zero});
    check({tag, ".rdata"},     mem_rdata,             e.rdata);
`ifdef DMEM_DEBUG_PORT_EN
    check({tag, ".debug"},     debug_data,            ref_mem[debug_addr[9:2]]);
`endif
    if (!rst) begin
      if (init_done && e.mem_write) ref_mem[e.res[9:2]] = rs2;
      else if (!init_done && init_w_enb) ref_mem[init_w_addr[9:2]] = init_w_dat;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    instruction = ins; rs1 = a; rs2 = b; immediate = imm;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; init_w_addr = '0; init_w_dat = '0; init_w_enb = 1'b0;
    drive(32'h01402623, 32'd0, 32'd3, 32'd12);
`ifdef DMEM_DEBUG_PORT_EN
    debug_addr = '0;
`endif
    step();

    // Reset: SW on the bus must not produce any controls.
    evaluate("reset");
    check("reset_mem_write", {31'd0, mem_write}, 32'd0);
    check("reset_reg_write", {31'd0, reg_write}, 32'd0);
    step();

    // Preload every word (bench model then knows all contents).
    rst = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 256; i++) begin
      init_w_addr = 10'(i * 4);
      init_w_dat = (i == 0) ? 32'd1 : (i == 1) ? 32'd2 : $urandom;
      init_w_enb = 1'b1;
      #1;
      ref_mem[i] = init_w_dat;
      step();
    end

    // Reset blocks a preload write.
    rst = 1'b1; init_w_addr = 10'h8; init_w_dat = 32'hdeadbeef;
    evaluate("rst_preload");
    step();
    rst = 1'b0; init_w_enb = 1'b0;
    // While not initialised, a store instruction does not reach memory.
    drive(32'h01402623, 32'd0, 32'h77, 32'd8);
    evaluate("sw_before_init");
    step();
    init_done = 1'b1;

`ifdef DMEM_DEBUG_PORT_EN
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    debug_addr = 10'h0; #1; check("dbg_0", debug_data, 32'd1);
    debug_addr = 10'h4; #1; check("dbg_4", debug_data, 32'd2);
    step();
`endif

    drive(32'h00002283, 32'd0, 32'd0, 32'd0);
    evaluate("lw0");
    check("lw0_rdata", mem_rdata, 32'd1);
    check("lw0_wbs", {30'd0, wrt_back_src}, 32'd1);
    step();
    drive(32'h00002283, 32'd0, 32'd0, 32'd4);
    evaluate("lw4");
    check("lw4_rdata", mem_rdata, 32'd2);
    step();
    drive(32'h00002283, 32'd0, 32'd0, 32'd8);
    evaluate("lw8");
    step();

    drive(32'h00628a33, 32'd1, 32'd2, 32'd0);
    evaluate("add");
    check("add_result", alu_results, 32'd3);
    check("add_zero", {31'd0, alu_zero}, 32'd0);
    step();
    drive(32'h40628a33, 32'd5, 32'd5, 32'd0);
    evaluate("sub");
    check("sub_zero", {31'd0, alu_zero}, 32'd1);
    step();

    drive(32'h01402623, 32'd0, 32'd3, 32'd12);
    evaluate("sw");
    check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    step();
`ifdef DMEM_DEBUG_PORT_EN
    debug_addr = 10'hC;
`endif
    drive(32'h00002283, 32'd0, 32'd0, 32'd12);
    evaluate("lw12");
    check("lw12_rdata", mem_rdata, 32'd3);
    step();

    drive(32'h00628063, 32'd7, 32'd7, 32'd0);
    evaluate("beq"); check("beq_branch", {31'd0, branch}, 32'd1); step();
    drive(32'h00629063, 32'd7, 32'd7, 32'd0);
    evaluate("bne"); check("bne_branch", {31'd0, branch}, 32'd0); step();
    drive(32'h0062c063, 32'hffffffff, 32'd1, 32'd0);
    evaluate("blt"); check("blt_branch", {31'd0, branch}, 32'd1); step();
    drive(32'h0062e063, 32'hffffffff, 32'd1, 32'd0);
    evaluate("bltu"); check("bltu_branch", {31'd0, branch}, 32'd0); step();

    rst = 1'b1;
    drive(32'h01402623, 32'd0, 32'h55, 32'd16);
    evaluate("rst_sw");
    check("rst_sw_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    rst = 1'b0;
    drive(32'h00002283, 32'd0, 32'd0, 32'd16);
    evaluate("lw16_after_rst");
    step();
    drive(32'h00000000, 32'd9, 32'd4, 32'd3);
    evaluate("nop");
    check("nop_reg_write", {31'd0, reg_write}, 32'd0);
    step();

    // Randomized mix of every instruction class, occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [6:0]  op;
      logic [2:0]  bf3;
      int          k;
      int          sel;
      ins = $urandom;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = $urandom;
      k = $urandom_range(0, 7);
      case (k)
        0: ins[6:0] = 7'h33;
        1, 7: ins[6:0] = 7'h13;
        2: begin ins[6:0] = 7'h03; imm = 32'($urandom_range(0, 4095)); end
        3: begin ins[6:0] = 7'h23; imm = 32'($urandom_range(0, 4095)); end
        4: begin
          ins[6:0] = 7'h63;
          sel = $urandom_range(0, 5);
          bf3 = (sel < 2) ? 3'(sel) : 3'(sel + 2);
          ins[14:12] = bf3;
        end
        5: ins[6:0] = 7'h6f;
        default: begin
          do op = 7'($urandom);
          while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
                 op == 7'h63 || op == 7'h6f);
          ins[6:0] = op;
        end
      endcase
      rst = ($urandom_range(0, 9) == 0);
`ifdef DMEM_DEBUG_PORT_EN
      debug_addr = 10'($urandom);
`endif
      drive(ins, a, b, imm);
      evaluate($sformatf("rand%0d", n));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
